// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : single-cycle ALU plus 32-step iterative multiply/divide. Rev 1.0
// ============================================================================
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_control,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   localparam logic [4:0] c_LAST_STEP = 5'd31;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d, result_q, result_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             neg_q, neg_d, ovf_pend_q, ovf_pend_d;
   logic             zero_q, zero_d, overflow_q, overflow_d, dbz_q, dbz_d;

   logic [WIDTH-1:0] w_sum, w_diff, w_alu_res, w_mag_a, w_mag_b;
   logic [WIDTH-1:0] w_mul_acc, w_div_rem, w_div_quo, w_mag_fin, w_fin;
   logic [WIDTH:0]   w_trial;
   logic [4:0]       w_sh;
   logic             w_alu_ovf, w_is_mul, w_is_div, w_signed;

   assign w_sum    = operand_a + operand_b;
   assign w_diff   = operand_a - operand_b;
   assign w_sh     = operand_b[4:0];
   assign w_is_mul = (alu_control[4:1] == 4'b0100);
   assign w_is_div = (alu_control[4:1] == 4'b0110);
   assign w_signed = alu_control[0];
   assign w_mag_a  = (w_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign w_mag_b  = (w_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (alu_control)
         5'b00000: w_alu_res = w_sum;
         5'b00001: begin
            w_alu_res = w_sum;
            w_alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         5'b00100: w_alu_res = w_diff;
         5'b00101: begin
            w_alu_res = w_diff;
            w_alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
         end
         5'b10000: w_alu_res = operand_a & operand_b;
         5'b10001: w_alu_res = operand_a | operand_b;
         5'b10010: w_alu_res = operand_a ^ operand_b;
         5'b10011: w_alu_res = ~operand_a;
         5'b10111: w_alu_res = ~(operand_a | operand_b);
         5'b10100: w_alu_res = operand_a << w_sh;
         5'b10101: w_alu_res = operand_a >> w_sh;
         5'b10110: w_alu_res = $unsigned($signed(operand_a) >>> w_sh);
         5'b11000: w_alu_res = WIDTH'(operand_a == operand_b);
         5'b11001: w_alu_res = WIDTH'(operand_a != operand_b);
         5'b11010: w_alu_res = WIDTH'($signed(operand_a) <  $signed(operand_b));
         5'b11011: w_alu_res = WIDTH'($signed(operand_a) >= $signed(operand_b));
         5'b11100: w_alu_res = WIDTH'(operand_a <  operand_b);
         5'b11101: w_alu_res = WIDTH'(operand_a >= operand_b);
         default:  w_alu_res = '0;
      endcase
   end

   // Shared datapath: MUL uses acc=partial product, x=multiplicand, y=multiplier;
   // DIV uses acc=remainder, x=dividend shifting into quotient, y=divisor.
   assign w_mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;
   assign w_trial   = {acc_q, x_q[WIDTH-1]} - {1'b0, y_q};
   assign w_div_rem = w_trial[WIDTH] ? {acc_q[WIDTH-2:0], x_q[WIDTH-1]} : w_trial[WIDTH-1:0];
   assign w_div_quo = {x_q[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_mag_fin = (state_q == MUL) ? w_mul_acc : w_div_quo;
   assign w_fin     = neg_q ? -w_mag_fin : w_mag_fin;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      x_d        = x_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      ovf_pend_d = ovf_pend_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cnt_d      = '0;
               acc_d      = '0;
               x_d        = w_mag_a;
               y_d        = w_mag_b;
               neg_d      = w_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
               ovf_pend_d = w_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (operand_b == {WIDTH{1'b1}});
               if (w_is_mul) begin
                  state_d = MUL;
               end else if (w_is_div && (operand_b != '0)) begin
                  state_d = DIV;
               end else if (w_is_div) begin
                  result_d   = '1;
                  zero_d     = 1'b0;
                  overflow_d = 1'b0;
                  dbz_d      = 1'b1;
                  state_d    = DONE;
               end else begin
                  result_d   = w_alu_res;
                  zero_d     = (w_alu_res == '0);
                  overflow_d = w_alu_ovf;
                  dbz_d      = 1'b0;
                  state_d    = DONE;
               end
            end
         end
         MUL, DIV: begin
            cnt_d = cnt_q + 5'd1;
            if (state_q == MUL) begin
               acc_d = w_mul_acc;
               x_d   = x_q << 1;
               y_d   = y_q >> 1;
            end else begin
               acc_d = w_div_rem;
               x_d   = w_div_quo;
            end
            if (cnt_q == c_LAST_STEP) begin
               result_d   = w_fin;
               zero_d     = (w_fin == '0);
               overflow_d = (state_q == DIV) && ovf_pend_q;
               dbz_d      = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         ovf_pend_q <= ovf_pend_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         dbz_q      <= dbz_d;
      end
   end

   assign in_ready    = (state_q == IDLE) && !rst;
   assign busy        = (state_q != IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign zero        = zero_q;
   assign overflow    = overflow_q;
   assign div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  unit can accept an operation.
REQ-006 alu_control  input  5  operation code from the ALU control unit.
REQ-007 operand_a  input  32  first operand (rs1).
REQ-008 operand_b  input  32  second operand (rs2 or immediate).
REQ-009 out_valid  output  1  result, zero, overflow and div_by_zero are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  32  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 overflow  output  1  signed overflow indication.
REQ-014 div_by_zero  output  1  divide with operand_b == 0.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, MUL, DIV, DONE; in_ready = (state == IDLE); busy = !in_ready.
REQ-017 An operation is accepted on a rising edge with in_valid && in_ready; operands and code are latched and are don't-care afterwards.
REQ-018 Single-cycle codes go IDLE->DONE with registered result; out_valid rises 1 cycle after acceptance.
REQ-019 Codes: 00000/00001 a+b; 00100/00101 a-b; 10000 a&b; 10001 a|b; 10010 a^b; 10011 ~a; 10111 ~(a|b); 10100 a<<b[4:0]; 10101 logical a>>b[4:0]; 10110 arithmetic a>>>b[4:0].
REQ-020 Compare codes set result to 32'd1 when true, else 32'd0: 11000 eq, 11001 ne, 11010 signed lt, 11011 signed ge, 11100 unsigned lt, 11101 unsigned ge.
REQ-021 Undefined codes: result 0, zero 1, overflow 0, div_by_zero 0, single-cycle latency.
REQ-022 overflow = signed overflow for 00001 and 00101 only; 0 for 00000, 00100 and every logic or compare code.
REQ-023 MUL codes (01000 unsigned, 01001 signed): IDLE->MUL, 32 iterative shift-add steps on magnitudes, sign applied at end; result = low 32 bits; out_valid rises 33 cycles after acceptance; overflow 0.
REQ-024 DIV codes (01100 unsigned, 01101 signed): IDLE->DIV, 32-step restoring division of magnitudes, quotient sign = sign(a)^sign(b); out_valid rises 33 cycles after acceptance.
REQ-025 Divide with b == 0: skip DIV, go directly to DONE (1-cycle latency); result 32'hFFFFFFFF, div_by_zero 1, overflow 0.
REQ-026 Signed divide 32'h80000000 / 32'hFFFFFFFF: result 32'h80000000, overflow 1, normal 33-cycle latency.
REQ-027 In DONE, out_valid = 1 and all outputs are held stable until out_valid && out_ready, then DONE->IDLE; in_ready stays 0 during that transfer cycle, so no overlap occurs.
REQ-028 in_valid is ignored while busy; no operation is queued.
REQ-029 zero is computed from the final registered result for every code.

Reset
REQ-030 rst high forces IDLE at once, including mid-MUL or mid-DIV; in-flight work is discarded.
REQ-031 While rst is high: out_valid 0, result 0, zero 0, overflow 0, div_by_zero 0, busy 0; in_ready goes to 1 once rst is low.

Verification
REQ-032 ADD_SIGNED a=32'h7FFFFFFF, b=1 -> one cycle later out_valid=1, result=32'h80000000, overflow=1, zero=0.
REQ-033 LT_SIGNED a=32'hFFFFFFFF, b=1 -> result 1; LT_UNSIGNED with the same operands -> result 0; SRA a=32'h80000000, b=4 -> result 32'hF8000000.
REQ-034 MUL_SIGNED a=-7, b=6 -> in_ready=0 for 33 cycles, then result=32'hFFFFFFD6; in_valid pulses during busy are ignored.
REQ-035 DIV_SIGNED a=-100, b=7 -> after 33 cycles result=32'hFFFFFFF2; DIV_UNSIGNED a=5, b=0 -> after 1 cycle result=32'hFFFFFFFF, div_by_zero=1.
REQ-036 Hold out_ready=0 for 5 cycles after an AND result -> outputs stay constant and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-037 Assert rst 10 cycles into a DIV -> outputs clear immediately; after release, an ADD 2+3 returns 5.
